// File: rtl/pfft_mul_pipe_su.sv
// Pipelined signed x unsigned multiplier with round/shift/saturate and a sideband tag.
// Latency NUM_STAGE cycles; one shared stage enable, so a stalled output freezes every stage.
module pfft_mul_pipe_su #(
    parameter int ID         = 1,
    parameter int NUM_STAGE  = 3,
    parameter int din0_WIDTH = 16,
    parameter int din1_WIDTH = 8,
    parameter int dout_WIDTH = 16,
    parameter int SHIFT      = 8,
    parameter int ROUND      = 1,
    parameter int SAT        = 1,
    parameter int TAG_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0] din1,
    input  logic [TAG_WIDTH-1:0]  in_tag,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [dout_WIDTH-1:0] dout,
    output logic [TAG_WIDTH-1:0]  out_tag,
    output logic                  sat
);

    localparam int P   = din0_WIDTH + din1_WIDTH + 1;
    localparam int RSH = (SHIFT > 0) ? SHIFT - 1 : 0;
    localparam logic [P:0] RND = (ROUND != 0 && SHIFT > 0) ? ((P+1)'(1) << RSH) : '0;

    typedef logic signed [P-1:0] prod_t;

    typedef struct packed {
        logic [dout_WIDTH-1:0] d;
        logic                  s;
    } res_t;

    // din1 is zero-extended so its top bit is magnitude, never sign.
    function automatic prod_t mul(input logic [din0_WIDTH-1:0] a,
                                  input logic [din1_WIDTH-1:0] b);
        prod_t ae;
        prod_t be;
        ae  = {{(P-din0_WIDTH){a[din0_WIDTH-1]}}, a};
        be  = {{(P-din1_WIDTH){1'b0}}, b};
        mul = ae * be;
    endfunction

    // One extra bit of headroom keeps the rounding add from wrapping.
    function automatic res_t post(input prod_t p);
        logic signed [P:0]         x;
        logic [P-dout_WIDTH+1:0]   hi;
        res_t                      r;
        x   = {p[P-1], p} + RND;
        x   = x >>> SHIFT;
        hi  = x[P:dout_WIDTH-1];
        r.d = x[dout_WIDTH-1:0];
        r.s = 1'b0;
        if (SAT != 0 && !((&hi) || !(|hi))) begin
            r.s = 1'b1;
            r.d = x[P] ? {1'b1, {(dout_WIDTH-1){1'b0}}} : {1'b0, {(dout_WIDTH-1){1'b1}}};
        end
        return r;
    endfunction

    logic                 adv;
    logic [NUM_STAGE-1:0] vld;
    logic [TAG_WIDTH-1:0] tg [NUM_STAGE];
    res_t                 res_q;

    assign adv       = !vld[NUM_STAGE-1] || out_ready;
    assign in_ready  = adv;
    assign out_valid = vld[NUM_STAGE-1];
    assign out_tag   = tg[NUM_STAGE-1];
    assign dout      = res_q.d;
    assign sat       = res_q.s;

    // Valid and tag travel as a plain shift register; bubbles move with the data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld <= '0;
            for (int k = 0; k < NUM_STAGE; k++) tg[k] <= '0;
        end else if (adv) begin
            vld[0] <= in_valid;
            tg[0]  <= in_tag;
            for (int k = 1; k < NUM_STAGE; k++) begin
                vld[k] <= vld[k-1];
                tg[k]  <= tg[k-1];
            end
        end
    end

    generate
        if (NUM_STAGE == 1) begin : g_one
            always_ff @(posedge clk or posedge reset) begin
                if (reset)    res_q <= '0;
                else if (adv) res_q <= post(mul(din0, din1));
            end
        end else begin : g_multi
            logic [din0_WIDTH-1:0] a_q;
            logic [din1_WIDTH-1:0] b_q;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (adv) begin
                    a_q <= din0;
                    b_q <= din1;
                end
            end

            if (NUM_STAGE == 2) begin : g_two
                always_ff @(posedge clk or posedge reset) begin
                    if (reset)    res_q <= '0;
                    else if (adv) res_q <= post(mul(a_q, b_q));
                end
            end else begin : g_deep
                // Multiply lands in stage 2; extra depth just retimes the product.
                prod_t p_q [2:NUM_STAGE-1];

                always_ff @(posedge clk or posedge reset) begin
                    if (reset) begin
                        for (int k = 2; k < NUM_STAGE; k++) p_q[k] <= '0;
                        res_q <= '0;
                    end else if (adv) begin
                        p_q[2] <= mul(a_q, b_q);
                        for (int k = 3; k < NUM_STAGE; k++) p_q[k] <= p_q[k-1];
                        res_q <= post(p_q[NUM_STAGE-1]);
                    end
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_pfft_mul_pipe_su.sv
// Three DUT configurations share one stimulus stream; each is tracked by its own
// fixed-depth slot model whose results come from plain integer arithmetic.
module tb_pfft_mul_pipe_su;

    localparam int NS [3] = '{3, 1, 5};
    localparam int SH [3] = '{8, 0, 0};
    localparam int RN [3] = '{1, 0, 0};
    localparam int SA [3] = '{1, 1, 0};

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic [15:0] din0 = '0;
    logic [7:0]  din1 = '0;
    logic [3:0]  in_tag = '0;

    logic        ir [3];
    logic        ov [3];
    logic        st [3];
    logic [15:0] dq [3];
    logic [3:0]  tq [3];

    int n_cmp = 0;
    int n_bad = 0;
    int n_out0 = 0;

    always #5 clk = ~clk;

    pfft_mul_pipe_su #(.ID(0), .NUM_STAGE(3), .din0_WIDTH(16), .din1_WIDTH(8), .dout_WIDTH(16),
        .SHIFT(8), .ROUND(1), .SAT(1), .TAG_WIDTH(4)) u0 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir[0]), .din0(din0), .din1(din1),
        .in_tag(in_tag), .out_valid(ov[0]), .out_ready(out_ready), .dout(dq[0]), .out_tag(tq[0]), .sat(st[0]));

    pfft_mul_pipe_su #(.ID(1), .NUM_STAGE(1), .din0_WIDTH(16), .din1_WIDTH(8), .dout_WIDTH(16),
        .SHIFT(0), .ROUND(0), .SAT(1), .TAG_WIDTH(4)) u1 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir[1]), .din0(din0), .din1(din1),
        .in_tag(in_tag), .out_valid(ov[1]), .out_ready(out_ready), .dout(dq[1]), .out_tag(tq[1]), .sat(st[1]));

    pfft_mul_pipe_su #(.ID(2), .NUM_STAGE(5), .din0_WIDTH(16), .din1_WIDTH(8), .dout_WIDTH(16),
        .SHIFT(0), .ROUND(0), .SAT(0), .TAG_WIDTH(4)) u2 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir[2]), .din0(din0), .din1(din1),
        .in_tag(in_tag), .out_valid(ov[2]), .out_ready(out_ready), .dout(dq[2]), .out_tag(tq[2]), .sat(st[2]));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic void model(input int i, input logic [15:0] a, input logic [7:0] b,
                                  output logic [15:0] d, output logic s);
        longint p;
        p = longint'($signed(a)) * longint'(b);
        if (RN[i] != 0 && SH[i] > 0) p = p + (longint'(1) << (SH[i] - 1));
        p = p >>> SH[i];
        d = p[15:0];
        s = 1'b0;
        if (SA[i] != 0) begin
            if (p > 32767) begin
                d = 16'h7FFF;
                s = 1'b1;
            end else if (p < -32768) begin
                d = 16'h8000;
                s = 1'b1;
            end
        end
    endfunction

    logic        mv [3][5];
    logic [15:0] md [3][5];
    logic [3:0]  mt [3][5];
    logic        ms [3][5];

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 3; i++)
                for (int k = 0; k < 5; k++) begin
                    mv[i][k] = 1'b0;
                    md[i][k] = '0;
                    mt[i][k] = '0;
                    ms[i][k] = 1'b0;
                end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (!mv[i][NS[i]-1] || out_ready) begin
                    for (int k = NS[i] - 1; k > 0; k--) begin
                        mv[i][k] = mv[i][k-1];
                        md[i][k] = md[i][k-1];
                        mt[i][k] = mt[i][k-1];
                        ms[i][k] = ms[i][k-1];
                    end
                    mv[i][0] = in_valid;
                    mt[i][0] = in_tag;
                    model(i, din0, din1, md[i][0], ms[i][0]);
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            logic eo;
            eo = mv[i][NS[i]-1];
            chk($sformatf("in_ready[%0d]", i), 32'(ir[i]), 32'(!eo || out_ready));
            chk($sformatf("out_valid[%0d]", i), 32'(ov[i]), 32'(eo));
            if (eo) begin
                chk($sformatf("dout[%0d]", i), 32'(dq[i]), 32'(md[i][NS[i]-1]));
                chk($sformatf("out_tag[%0d]", i), 32'(tq[i]), 32'(mt[i][NS[i]-1]));
                chk($sformatf("sat[%0d]", i), 32'(st[i]), 32'(ms[i][NS[i]-1]));
            end
        end
    end

    always @(posedge clk) if (!reset && ov[0] && out_ready) n_out0++;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] a, input logic [7:0] b, input logic [3:0] t);
        in_valid = 1'b1;
        din0 = a;
        din1 = b;
        in_tag = t;
        cyc();
        in_valid = 1'b0;
    endtask

    initial begin
        logic [15:0] d;
        logic        s;
        int          idx;
        int          c;
        int          base;

        // Hand-computed anchors for the reference model.
        model(0, 16'hFFFD, 8'd255, d, s); chk("pin_neg3x255", {d, 15'b0, s}, {16'hFFFD, 16'h0000});
        model(0, 16'h0001, 8'h80, d, s);  chk("pin_1x128_round", {d, 15'b0, s}, {16'h0001, 16'h0000});
        model(1, 16'h8000, 8'd255, d, s); chk("pin_min_sat", {d, 15'b0, s}, {16'h8000, 16'h0001});
        model(2, 16'h8000, 8'd255, d, s); chk("pin_min_wrap", {d, 15'b0, s}, {16'h8000, 16'h0000});
        model(1, 16'h7FFF, 8'd2, d, s);   chk("pin_max_sat", {d, 15'b0, s}, {16'h7FFF, 16'h0001});
        model(2, 16'h7FFF, 8'd2, d, s);   chk("pin_max_wrap", {d, 15'b0, s}, {16'hFFFE, 16'h0000});

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        cyc();
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rst_out_valid[%0d]", i), 32'(ov[i]), 32'd0);
            chk($sformatf("rst_dout[%0d]", i), 32'(dq[i]), 32'd0);
            chk($sformatf("rst_sat[%0d]", i), 32'(st[i]), 32'd0);
            chk($sformatf("rst_in_ready[%0d]", i), 32'(ir[i]), 32'd1);
        end

        // Exact latency for the default and the single-stage configurations.
        send(16'hFFFD, 8'd255, 4'd5);
        chk("lat_ns1_valid", 32'(ov[1]), 32'd1);
        chk("lat_ns1_dout", 32'(dq[1]), 32'h0000FD03);
        chk("lat_ns3_edge0", 32'(ov[0]), 32'd0);
        cyc();
        chk("lat_ns3_edge1", 32'(ov[0]), 32'd0);
        cyc();
        chk("lat_ns3_edge2", 32'(ov[0]), 32'd1);
        chk("lat_ns3_dout", 32'(dq[0]), 32'h0000FFFD);
        chk("lat_ns3_tag", 32'(tq[0]), 32'd5);
        chk("lat_ns3_sat", 32'(st[0]), 32'd0);
        repeat (6) cyc();

        send(16'h0001, 8'h80, 4'd1);
        send(16'h8000, 8'd255, 4'd2);
        send(16'h7FFF, 8'd2, 4'd3);
        repeat (8) cyc();

        // Eight pairs handshaken against the default instance, with a 5-cycle stall mid-stream.
        base = n_out0;
        idx = 0;
        c = 0;
        while (idx < 8 && c < 40) begin
            logic acc;
            in_valid  = 1'b1;
            din0      = 16'(idx * 1234 - 4000);
            din1      = 8'(idx * 37 + 3);
            in_tag    = 4'(idx + 8);
            out_ready = !(c >= 4 && c < 9);
            @(negedge clk);
            acc = ir[0];
            cyc();
            if (acc) idx++;
            c++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        if (idx < 8) chk("t4_timeout", 32'(idx), 32'd8);
        repeat (8) cyc();
        chk("t4_out_count", 32'(n_out0 - base), 32'd8);

        // Reset with operations in flight.
        send(16'h1234, 8'd200, 4'd9);
        send(16'hC000, 8'd99, 4'd10);
        #2 reset = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rst_flight_valid[%0d]", i), 32'(ov[i]), 32'd0);
            chk($sformatf("rst_flight_dout[%0d]", i), 32'(dq[i]), 32'd0);
        end
        cyc();
        reset = 1'b0;
        base = n_out0;
        repeat (8) cyc();
        chk("rst_no_stale", 32'(n_out0 - base), 32'd0);

        // Random sweep.
        for (int n = 0; n < 3000; n++) begin
            int r;
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 6);
            r = int'($urandom_range(0, 7));
            din0 = (r == 0) ? 16'h8000 : (r == 1) ? 16'h7FFF : 16'($urandom);
            r = int'($urandom_range(0, 7));
            din1 = (r == 0) ? 8'd255 : (r == 1) ? 8'd0 : 8'($urandom);
            in_tag = 4'($urandom);
            cyc();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (8) cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
